// File: rtl/svm_cfg_pkg.sv
// Shared types and sizing for the SVM configuration sequencer.
package svm_cfg_pkg;

    localparam int COEF_W = 16;               // coefficient / bias width
    localparam int N_COEF = 105;              // coefficients per RAM row
    localparam int N_WORD = 36;               // RAM rows per model
    localparam int ADDR_W = 6;                // RAM address width
    localparam int RAM_DW = COEF_W * N_COEF;  // RAM row width
    localparam int BEAT_W = 7;                // holds 0..N_COEF-1

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_BIAS  = 3'd3,
        ST_RUN   = 3'd4,
        ST_DRAIN = 3'd5
    } state_e;

endpackage

// File: rtl/svm_cfg_ctrl_coef_row_assembler.sv
// Packs one host coefficient per beat into a full RAM row, lowest slice first.
module coef_row_assembler
    import svm_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              beat_i,
    input  logic [COEF_W-1:0] data_i,
    output logic              row_full_o,
    output logic [RAM_DW-1:0] row_o
);

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [RAM_DW-1:0] row_q, row_d;

    // Flags the beat that completes the row so the FSM can write it next cycle.
    assign row_full_o = beat_i && (beat_cnt_q == BEAT_W'(N_COEF - 1));
    assign row_o      = row_q;

    // Next-state: drop the beat into its slice and advance, wrapping after the last slice.
    always_comb begin
        row_d      = row_q;
        beat_cnt_d = beat_cnt_q;
        if (clr_i) begin
            beat_cnt_d = '0;
        end else if (beat_i) begin
            row_d[int'(beat_cnt_q) * COEF_W +: COEF_W] = data_i;
            beat_cnt_d = row_full_o ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // Row and beat counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_q <= '0;
            row_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            row_q      <= row_d;
        end
    end

endmodule

// File: rtl/svm_cfg_ctrl.sv
// Load/run sequencer: streams the SVM model into RAM, loads the bias, then
// gates pixel fetch; a reload first drains the pipeline for DRAIN_CYC cycles.
module svm_cfg_ctrl
    import svm_cfg_pkg::*;
#(
    parameter int DRAIN_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic              host_valid,
    input  logic [COEF_W-1:0] host_data,
    output logic              host_ready,
    output logic [ADDR_W-1:0] addr_a,
    output logic              write_en,
    output logic [RAM_DW-1:0] ram_wdata,
    output logic [COEF_W-1:0] bias,
    output logic              b_load,
    input  logic              fifo_ready_in,
    output logic              hog_ready,
    output logic              run_en,
    output logic              busy,
    output logic              done
);

    localparam int DRN_W = $clog2(DRAIN_CYC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [COEF_W-1:0] bias_q, bias_d;
    logic              run_en_q, run_en_d;
    logic              b_load_q, b_load_d;
    logic              done_q, done_d;
    logic              accept, row_beat, row_full, clr_row;
    logic [RAM_DW-1:0] row;

    assign busy       = (state_q == ST_LOAD) || (state_q == ST_WRITE) ||
                        (state_q == ST_BIAS) || (state_q == ST_DRAIN);
    assign host_ready = (state_q == ST_LOAD) || (state_q == ST_BIAS);
    // An aborting cycle never consumes a beat, so abort always wins.
    assign accept     = host_valid && host_ready && !cfg_abort;
    assign row_beat   = accept && (state_q == ST_LOAD);

    assign addr_a    = word_idx_q;
    assign write_en  = (state_q == ST_WRITE);
    assign ram_wdata = row;
    assign bias      = bias_q;
    assign b_load    = b_load_q;
    assign done      = done_q;
    assign run_en    = run_en_q;
    assign hog_ready = fifo_ready_in && run_en_q;

    coef_row_assembler u_row (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_row),
        .beat_i     (row_beat),
        .data_i     (host_data),
        .row_full_o (row_full),
        .row_o      (row)
    );

    // Next-state logic for the sequencer; abort from any loading/draining state has priority.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        drain_cnt_d = drain_cnt_q;
        bias_d      = bias_q;
        run_en_d    = run_en_q;
        b_load_d    = 1'b0;
        done_d      = 1'b0;
        clr_row     = 1'b0;
        if (cfg_abort && busy) begin
            state_d     = ST_IDLE;
            word_idx_d  = '0;
            drain_cnt_d = '0;
            run_en_d    = 1'b0;
            clr_row     = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state_d    = ST_LOAD;
                        word_idx_d = '0;
                        clr_row    = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (row_full) state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    if (word_idx_q == ADDR_W'(N_WORD - 1)) begin
                        state_d = ST_BIAS;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = ST_LOAD;
                    end
                end
                ST_BIAS: begin
                    if (accept) begin
                        bias_d   = host_data;
                        state_d  = ST_RUN;
                        run_en_d = 1'b1;
                        b_load_d = 1'b1;
                        done_d   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cfg_start) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                        run_en_d    = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRN_W'(DRAIN_CYC - 1)) begin
                        state_d     = ST_LOAD;
                        word_idx_d  = '0;
                        drain_cnt_d = '0;
                        clr_row     = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            word_idx_q  <= '0;
            drain_cnt_q <= '0;
            bias_q      <= '0;
            run_en_q    <= 1'b0;
            b_load_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            drain_cnt_q <= drain_cnt_d;
            bias_q      <= bias_d;
            run_en_q    <= run_en_d;
            b_load_q    <= b_load_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_svm_cfg_ctrl.sv
// Directed bench for svm_cfg_ctrl.
module tb_svm_cfg_ctrl;
    import svm_cfg_pkg::*;

    logic              clk;
    logic              rst;
    logic              cfg_start;
    logic              cfg_abort;
    logic              host_valid;
    logic [COEF_W-1:0] host_data;
    logic              host_ready;
    logic [ADDR_W-1:0] addr_a;
    logic              write_en;
    logic [RAM_DW-1:0] ram_wdata;
    logic [COEF_W-1:0] bias;
    logic              b_load;
    logic              fifo_ready_in;
    logic              hog_ready;
    logic              run_en;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    // Passive monitor state (written only by the monitor process)
    logic [RAM_DW-1:0] rows_mem [0:N_WORD-1];
    int                wr_log   [0:255];
    int                wr_total   = 0;
    int                hr_in_wr   = 0;
    int                hog_bad    = 0;
    int                bl_total   = 0;
    int                dn_total   = 0;
    int                bl_dn_same = 0;

    svm_cfg_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .host_valid    (host_valid),
        .host_data     (host_data),
        .host_ready    (host_ready),
        .addr_a        (addr_a),
        .write_en      (write_en),
        .ram_wdata     (ram_wdata),
        .bias          (bias),
        .b_load        (b_load),
        .fifo_ready_in (fifo_ready_in),
        .hog_ready     (hog_ready),
        .run_en        (run_en),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (write_en) begin
            if (wr_total < 256) wr_log[wr_total] = int'(addr_a);
            if (int'(addr_a) < N_WORD) rows_mem[addr_a] = ram_wdata;
            wr_total++;
            if (host_ready) hr_in_wr++;
        end
        if (hog_ready && !run_en) hog_bad++;
        if (b_load) bl_total++;
        if (done) dn_total++;
        if (b_load && done) bl_dn_same++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Streams n beats of value base+i; host holds each beat until accepted.
    task automatic send(input int base, input int n, input bit tgl);
        int  i     = 0;
        int  guard = 0;
        logic hr;
        while (i < n && guard < 4 * n + 100) begin
            host_valid = 1'b1;
            host_data  = COEF_W'(base + i);
            #1;
            hr = host_ready;
            @(posedge clk);
            @(negedge clk);
            if (hr) i++;
            guard++;
            if (tgl) begin
                host_valid = 1'b0;
                host_data  = 16'hDEAD;
                @(posedge clk);
                @(negedge clk);
            end
        end
        host_valid = 1'b0;
        chk("send_beats_accepted", 64'(i), 64'(n));
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    function automatic int row_errs(input int base, input int nrows);
        int e = 0;
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < N_COEF; c++)
                if (rows_mem[r][c*COEF_W +: COEF_W] !== COEF_W'(base + r * N_COEF + c)) e++;
        return e;
    endfunction

    function automatic int addr_errs(input int start, input int n);
        int e = 0;
        for (int k = 0; k < n; k++)
            if (wr_log[start + k] != k) e++;
        return e;
    endfunction

    initial begin
        int snap;
        int cnt;
        logic [COEF_W-1:0] s;

        rst           = 1'b0;
        cfg_start     = 1'b0;
        cfg_abort     = 1'b0;
        host_valid    = 1'b0;
        host_data     = '0;
        fifo_ready_in = 1'b1;

        // ---- reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_host_ready", 64'(host_ready), 64'd0);
        chk("rst_write_en",  64'(write_en), 64'd0);
        chk("rst_run_en",    64'(run_en), 64'd0);
        chk("rst_hog_ready", 64'(hog_ready), 64'd0);
        chk("rst_done",      64'(done), 64'd0);
        chk("rst_b_load",    64'(b_load), 64'd0);
        chk("rst_bias",      64'(bias), 64'd0);
        chk("rst_wdata_or",  64'(|ram_wdata), 64'd0);
        chk("rst_addr",      64'(addr_a), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // ---- full back-to-back load, value = index
        pulse_start();
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_host_ready", 64'(host_ready), 64'd1);
        snap = wr_total;
        send(0, N_WORD * N_COEF + 1, 1'b0);
        chk("l1_b_load", 64'(b_load), 64'd1);
        chk("l1_done",   64'(done), 64'd1);
        chk("l1_run_en", 64'(run_en), 64'd1);
        chk("l1_bias",   64'(bias), 64'h0EC4);
        chk("l1_busy",   64'(busy), 64'd0);
        chk("l1_writes", 64'(wr_total - snap), 64'd36);
        chk("l1_addr_seq_errs", 64'(addr_errs(snap, 36)), 64'd0);
        s = rows_mem[0][0 +: COEF_W];
        chk("l1_row0_slice0", 64'(s), 64'h0000);
        s = rows_mem[0][104*COEF_W +: COEF_W];
        chk("l1_row0_slice104", 64'(s), 64'h0068);
        chk("l1_row_data_errs", 64'(row_errs(0, 36)), 64'd0);
        @(negedge clk);
        chk("l1_b_load_gone", 64'(b_load), 64'd0);
        chk("l1_done_gone",   64'(done), 64'd0);
        chk("l1_run_en_hold", 64'(run_en), 64'd1);
        chk("l1_bias_hold",   64'(bias), 64'h0EC4);

        // ---- hog_ready follows fifo_ready_in in RUN
        fifo_ready_in = 1'b0; #1;
        chk("hog_follow_0", 64'(hog_ready), 64'd0);
        fifo_ready_in = 1'b1; #1;
        chk("hog_follow_1", 64'(hog_ready), 64'd1);
        @(negedge clk);
        fifo_ready_in = 1'b0; #1;
        chk("hog_follow_0b", 64'(hog_ready), 64'd0);
        fifo_ready_in = 1'b1; #1;

        // ---- abort ignored in RUN
        @(negedge clk);
        cfg_abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_abort = 1'b0;
        chk("run_abort_ignored", 64'(run_en), 64'd1);

        // ---- reload: drain window
        pulse_start();
        chk("drain_run_en", 64'(run_en), 64'd0);
        chk("drain_hog",    64'(hog_ready), 64'd0);
        chk("drain_busy",   64'(busy), 64'd1);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (host_ready) break;
            cnt++;
            @(negedge clk);
        end
        chk("drain_hr_low_cycles", 64'(cnt), 64'd64);

        // ---- toggled host valid, 10 rows plus 50 beats, then abort
        snap = wr_total;
        send(32'h1000, 10 * N_COEF + 50, 1'b1);
        chk("tgl_writes", 64'(wr_total - snap), 64'd10);
        chk("tgl_addr_seq_errs", 64'(addr_errs(snap, 10)), 64'd0);
        chk("tgl_row_data_errs", 64'(row_errs(32'h1000, 10)), 64'd0);
        cfg_abort  = 1'b1;
        host_valid = 1'b1;
        host_data  = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        cfg_abort  = 1'b0;
        host_valid = 1'b0;
        chk("abort_busy",   64'(busy), 64'd0);
        chk("abort_run_en", 64'(run_en), 64'd0);
        chk("abort_hr",     64'(host_ready), 64'd0);
        chk("abort_no_write", 64'(wr_total - snap), 64'd10);

        // ---- restart after abort, full load from addr 0 beat 0
        pulse_start();
        snap = wr_total;
        send(32'h2000, N_WORD * N_COEF + 1, 1'b0);
        chk("l2_done",   64'(done), 64'd1);
        chk("l2_bias",   64'(bias), 64'h2EC4);
        chk("l2_writes", 64'(wr_total - snap), 64'd36);
        chk("l2_addr_seq_errs", 64'(addr_errs(snap, 36)), 64'd0);
        s = rows_mem[0][0 +: COEF_W];
        chk("l2_row0_slice0", 64'(s), 64'h2000);
        chk("l2_row_data_errs", 64'(row_errs(32'h2000, 36)), 64'd0);
        @(negedge clk);
        chk("l2_run_en", 64'(run_en), 64'd1);

        // ---- async reset in the middle of a WRITE cycle
        pulse_start();
        repeat (64) @(negedge clk);
        send(32'h3000, N_COEF, 1'b0);
        chk("mid_write_we", 64'(write_en), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_write_en", 64'(write_en), 64'd0);
        chk("arst_busy",     64'(busy), 64'd0);
        chk("arst_wdata_or", 64'(|ram_wdata), 64'd0);
        chk("arst_bias",     64'(bias), 64'd0);
        chk("arst_run_en",   64'(run_en), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_hr",   64'(host_ready), 64'd0);

        // ---- monitor totals
        chk("hr_during_write", 64'(hr_in_wr), 64'd0);
        chk("hog_without_run", 64'(hog_bad), 64'd0);
        chk("b_load_pulses",   64'(bl_total), 64'd2);
        chk("done_pulses",     64'(dn_total), 64'd2);
        chk("b_load_done_same", 64'(bl_dn_same), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
